// File: rtl/fpga_transmitter_state_if.sv
// Handshake bundle between a word source and the serial frame transmitter.
// The master drives the request and the receiver's acknowledge; the slave is the transmitter.
interface fpga_transmitter_state_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             acknowledge;
  logic             send;
  logic             finish;
  logic             data_out;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, data_in, acknowledge,
    input  send, finish, data_out, busy, done, error
  );

  modport slave (
    input  start, data_in, acknowledge,
    output send, finish, data_out, busy, done, error
  );
endinterface

// File: rtl/fpga_transmitter_state.sv
// Serial frame transmitter: frame-start handshake, WIDTH MSB-first data bits, finish handshake.
// Each handshake waits for a synchronized acknowledge edge and aborts after TIMEOUT cycles.
//
// state      | meaning
// IDLE       | waiting for start; word latched on acceptance
// FRAME_SEND | one-cycle send pulse announcing the frame
// FRAME_WAIT | waiting for the frame-start acknowledge
// BIT_SETUP  | data_out settles on the current MSB
// BIT_SEND   | one-cycle send pulse for the current bit
// BIT_WAIT   | bit held until acknowledged, then shift
// FIN_WAIT   | finish held until acknowledged
// DONE       | one-cycle done pulse
// ERROR      | one-cycle error pulse after a wait timed out
module fpga_transmitter_state #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input logic                  clock,
  input logic                  reset,
  fpga_transmitter_state_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [15:0]       TMR_LOAD = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    FRAME_SEND,
    FRAME_WAIT,
    BIT_SETUP,
    BIT_SEND,
    BIT_WAIT,
    FIN_WAIT,
    DONE,
    ERROR
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             ack_s1;
  logic             ack_s2;
  logic             ack_prev;
  logic             ack_edge;

  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [15:0]      wait_tmr;
  logic             in_wait;
  logic             next_is_wait;
  logic             wait_expired;

  logic             send_q;
  logic             finish_q;
  logic             data_out_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_s1   <= bus.acknowledge;
      ack_s2   <= ack_s1;
      ack_prev <= ack_s2;
    end
  end

  // A one-cycle edge: an edge landing outside a wait state is simply lost.
  assign ack_edge     = ack_s2 & ~ack_prev;
  assign in_wait      = (state == FRAME_WAIT) || (state == BIT_WAIT) || (state == FIN_WAIT);
  assign next_is_wait = (state_next == FRAME_WAIT) || (state_next == BIT_WAIT) ||
                        (state_next == FIN_WAIT);
  assign wait_expired = (wait_tmr == 16'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = FRAME_SEND;
        end
      end
      FRAME_SEND: state_next = FRAME_WAIT;
      FRAME_WAIT: begin
        if (ack_edge) begin
          state_next = BIT_SETUP;
        end else if (wait_expired) begin
          state_next = ERROR;
        end
      end
      BIT_SETUP: state_next = BIT_SEND;
      BIT_SEND:  state_next = BIT_WAIT;
      BIT_WAIT: begin
        if (ack_edge) begin
          state_next = (bit_cnt == BIT_LAST) ? FIN_WAIT : BIT_SETUP;
        end else if (wait_expired) begin
          state_next = ERROR;
        end
      end
      FIN_WAIT: begin
        if (ack_edge) begin
          state_next = DONE;
        end else if (wait_expired) begin
          state_next = ERROR;
        end
      end
      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The wait timer counts down from TIMEOUT-1 loaded on entry; reaching zero
  // without an edge means TIMEOUT-1 cycles have elapsed in that wait.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      wait_tmr  <= 16'd0;
    end else begin
      if ((state == IDLE) && bus.start) begin
        shift_reg <= bus.data_in;
        bit_cnt   <= '0;
      end else if ((state == BIT_WAIT) && ack_edge) begin
        shift_reg <= shift_reg << 1;
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end

      if (next_is_wait && (state_next != state)) begin
        wait_tmr <= TMR_LOAD;
      end else if (in_wait && !wait_expired) begin
        wait_tmr <= wait_tmr - 16'd1;
      end
    end
  end

  always_comb begin
    send_q     = 1'b0;
    finish_q   = 1'b0;
    data_out_q = 1'b0;
    busy_q     = (state != IDLE);
    done_q     = 1'b0;
    error_q    = 1'b0;
    case (state)
      FRAME_SEND: send_q = 1'b1;
      BIT_SETUP:  data_out_q = shift_reg[WIDTH-1];
      BIT_SEND: begin
        send_q     = 1'b1;
        data_out_q = shift_reg[WIDTH-1];
      end
      BIT_WAIT:   data_out_q = shift_reg[WIDTH-1];
      FIN_WAIT:   finish_q = 1'b1;
      DONE:       done_q = 1'b1;
      ERROR:      error_q = 1'b1;
      default:    ;
    endcase
  end

  assign bus.send     = send_q;
  assign bus.finish   = finish_q;
  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule
